// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection, stall control and operand forwarding selects
//
// Purpose:
//   Tracks shadow copies of the EX and MEM pipeline stages and compares them
//   with the source registers of the instruction in ID. It then either stalls
//   the front end or registers forwarding selects for the next EX cycle.
//
// Configuration:
//   HAZARD_FORWARDING_EN defined   : only load-use hazards stall. fwd_a/fwd_b
//                                    select EX/MEM (1) or MEM/WB (2) results.
//   HAZARD_FORWARDING_EN undefined : any RAW dependency on EX or MEM stalls.
//                                    fwd_a/fwd_b are constant 0.
//
// Ports:
//   clk, rst_n                 pipeline clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source register numbers
//   id_uses_rs, id_uses_rt     ID instruction reads rs / rt
//   id_reg_write, id_mem_read  ID instruction writes a register / is a load
//   id_dst                     ID destination register
//   branch_taken               ID branch resolved taken
//   stall                      hold PC and IF/ID, inject a bubble into EX
//   flush_ifid                 clear IF/ID
//   fwd_a, fwd_b               registered EX operand selects (0 RF, 1 EX/MEM, 2 MEM/WB)
//   stall_count                saturating count of stall cycles

module hazard_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic [4:0]  id_dst,
    input  logic        branch_taken,
    output logic        stall,
    output logic        flush_ifid,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] dst;
    } rec_t;

    typedef enum logic {RUN, STALL} state_t;

    rec_t   ex_q;
    rec_t   mem_q;
    state_t state_q;
    state_t state_d;
    logic   hazard;
    logic   rs_ex, rt_ex, rs_mem, rt_mem;

    // r0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic src_match(input logic valid, input logic uses,
                                       input rec_t r, input logic [4:0] src);
        return valid & uses & r.valid & r.reg_write & (r.dst == src) & (src != 5'd0);
    endfunction

    assign rs_ex  = src_match(id_valid, id_uses_rs, ex_q,  id_rs);
    assign rt_ex  = src_match(id_valid, id_uses_rt, ex_q,  id_rt);
    assign rs_mem = src_match(id_valid, id_uses_rs, mem_q, id_rs);
    assign rt_mem = src_match(id_valid, id_uses_rt, mem_q, id_rt);

`ifdef HAZARD_FORWARDING_EN
    // Everything but a load result in EX can be forwarded in time.
    assign hazard = (rs_ex | rt_ex) & ex_q.mem_read;
`else
    // Without forwarding, the value is only readable once the producer is in WB.
    assign hazard = rs_ex | rt_ex | rs_mem | rt_mem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // stall is combinational on the live hazard in both states, so the FSM
    // leaves STALL on the first edge the hazard has cleared.
    always_comb begin
        state_d = RUN;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                stall   = hazard;
                state_d = hazard ? STALL : RUN;
            end
            STALL: begin
                stall   = hazard;
                state_d = hazard ? STALL : RUN;
            end
            default: begin
                stall   = 1'b0;
                state_d = RUN;
            end
        endcase
    end

    // A taken branch is deferred while stalling; ID still holds the branch.
    assign flush_ifid = branch_taken & id_valid & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
            if (stall) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid: id_valid, reg_write: id_reg_write,
                          mem_read: id_mem_read, dst: id_dst};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // EX is the younger producer, so it wins when both stages match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= 2'd0;
            fwd_b <= 2'd0;
        end else if (stall) begin
            fwd_a <= 2'd0;
            fwd_b <= 2'd0;
        end else begin
            fwd_a <= rs_ex ? 2'd1 : (rs_mem ? 2'd2 : 2'd0);
            fwd_b <= rt_ex ? 2'd1 : (rt_mem ? 2'd2 : 2'd0);
        end
    end
`else
    assign fwd_a = 2'd0;
    assign fwd_b = 2'd0;
`endif

    // The load flag is carried along for visibility but never consulted in MEM.
    logic unused_rec_bits;
    assign unused_rec_bits = mem_q.mem_read ^ ex_q.mem_read;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized self-checking bench for hazard_unit against a pipeline model

module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic        branch_taken;
    logic        stall, flush_ifid;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_dst       (id_dst),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush_ifid   (flush_ifid),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Instructions in flight: pipe[0] is in EX, pipe[1] is in MEM.
    typedef struct {
        bit       v;
        bit       rw;
        bit       mr;
        bit [4:0] d;
    } ins_t;

    ins_t        pipe [2];
    int unsigned m_cnt;
    bit [1:0]    m_fa, m_fb;
    bit          m_stall, m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit reads(input ins_t p, input bit uses, input bit [4:0] s);
        return id_valid && uses && p.v && p.rw && (p.d == s) && (s != 0);
    endfunction

    function automatic bit [1:0] fwd_sel(input bit uses, input bit [4:0] s);
        if (reads(pipe[0], uses, s)) return 2'd1;
        if (reads(pipe[1], uses, s)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        pipe[0] = '{v: 0, rw: 0, mr: 0, d: 0};
        pipe[1] = '{v: 0, rw: 0, mr: 0, d: 0};
        m_cnt = 0;
        m_fa  = 0;
        m_fb  = 0;
    endtask

    task automatic model_comb();
        bit ex_dep, mem_dep;
        ex_dep  = reads(pipe[0], id_uses_rs, id_rs) || reads(pipe[0], id_uses_rt, id_rt);
        mem_dep = reads(pipe[1], id_uses_rs, id_rs) || reads(pipe[1], id_uses_rt, id_rt);
`ifdef HAZARD_FORWARDING_EN
        m_stall = ex_dep && pipe[0].mr;
`else
        m_stall = ex_dep || mem_dep;
`endif
        m_flush = branch_taken && id_valid && !m_stall;
    endtask

    task automatic model_edge();
`ifdef HAZARD_FORWARDING_EN
        m_fa = m_stall ? 2'd0 : fwd_sel(id_uses_rs, id_rs);
        m_fb = m_stall ? 2'd0 : fwd_sel(id_uses_rt, id_rt);
`else
        m_fa = 2'd0;
        m_fb = 2'd0;
`endif
        if (m_stall && m_cnt < 65535) m_cnt++;
        pipe[1] = pipe[0];
        if (m_stall) pipe[0] = '{v: 0, rw: 0, mr: 0, d: 0};
        else pipe[0] = '{v: id_valid, rw: id_reg_write, mr: id_mem_read, d: id_dst};
    endtask

    task automatic drive_rand();
        id_valid     = ($urandom_range(0, 99) < 85);
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        id_dst       = 5'($urandom_range(0, 3));
        id_uses_rs   = ($urandom_range(0, 99) < 80);
        id_uses_rt   = ($urandom_range(0, 99) < 60);
        id_reg_write = ($urandom_range(0, 99) < 75);
        id_mem_read  = ($urandom_range(0, 99) < 40);
        branch_taken = ($urandom_range(0, 99) < 25);
    endtask

    task automatic drive(input bit v, input bit [4:0] rs, input bit urs, input bit [4:0] rt,
                         input bit urt, input bit rw, input bit mr, input bit [4:0] dst,
                         input bit br);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_reg_write = rw; id_mem_read = mr; id_dst = dst; branch_taken = br;
    endtask

    // Called just after a falling edge with ID inputs already driven.
    task automatic run_cycle();
        #1;
        model_comb();
        check("stall", 32'(stall), 32'(m_stall));
        check("flush_ifid", 32'(flush_ifid), 32'(m_flush));
        @(posedge clk);
        model_edge();
        #1;
        check("fwd_a", 32'(fwd_a), 32'(m_fa));
        check("fwd_b", 32'(fwd_b), 32'(m_fb));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state, with ID asking for r1 so only the empty records keep stall low.
        drive(1, 5'd1, 1, 5'd1, 1, 1, 1, 5'd1, 1);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush_ifid), 32'd1);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);
        check("rst_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load r5, then a reader of r5 alongside a taken branch.
        drive(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd5, 0);
        run_cycle();
        @(negedge clk);
        drive(1, 5'd5, 1, 5'd0, 0, 1, 0, 5'd6, 1);
        run_cycle();
        @(negedge clk);
        run_cycle();
        @(negedge clk);
        run_cycle();

        // Same-register double match, then r0 in both stages.
        @(negedge clk); drive(1, 0, 0, 0, 0, 1, 0, 5'd3, 0); run_cycle();
        @(negedge clk); drive(1, 0, 0, 0, 0, 1, 0, 5'd3, 0); run_cycle();
        @(negedge clk); drive(1, 5'd3, 1, 0, 0, 0, 0, 5'd0, 0); run_cycle();
        @(negedge clk); drive(1, 0, 0, 0, 0, 1, 0, 5'd0, 0); run_cycle();
        @(negedge clk); drive(1, 0, 0, 0, 0, 1, 0, 5'd0, 0); run_cycle();
        @(negedge clk); drive(1, 5'd0, 1, 5'd0, 1, 0, 0, 5'd0, 0); run_cycle();

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_rand();
            run_cycle();
        end

        // Reset in the middle of a load-use stall.
        @(negedge clk); drive(1, 0, 0, 0, 0, 1, 1, 5'd5, 0); run_cycle();
        @(negedge clk); drive(1, 5'd5, 1, 0, 0, 1, 0, 5'd6, 0);
        #1;
        check("pre_rst_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_fwd_a", 32'(fwd_a), 32'd0);
        check("mid_rst_fwd_b", 32'(fwd_b), 32'd0);
        check("mid_rst_count", 32'(stall_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            @(negedge clk);
        end
        for (int i = 0; i < 200; i++) begin
            drive_rand();
            run_cycle();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
